// File: rtl/pipe_world_pkg.sv
// pipe_world_pkg: shared types and the grid-neighbour helper for the pipe-world model.
package pipe_world_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        CELL_FREE  = 2'd0,
        CELL_WALL  = 2'd1,
        CELL_TRASH = 2'd2,
        CELL_EXIT  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FLT_NONE    = 2'd0,
        FLT_COLLIDE = 2'd1,
        FLT_MULTI   = 2'd2,
        FLT_BAD     = 2'd3
    } fault_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               oob;
    } nbr_t;

    // Neighbour of (x, y) in direction dir on a w x h grid; oob flags leaving the grid.
    function automatic nbr_t neighbour(input int x, input int y, input logic [1:0] dir,
                                       input int w, input int h);
        nbr_t n;
        int   nx;
        int   ny;
        nx = x;
        ny = y;
        case (dir)
            2'd0:    ny = y + 32'sd1;
            2'd1:    nx = x + 32'sd1;
            2'd2:    ny = y - 32'sd1;
            2'd3:    nx = x - 32'sd1;
            default: ny = y;
        endcase
        n.oob = (nx < 32'sd0) || (nx >= w) || (ny < 32'sd0) || (ny >= h);
        n.x   = nx[COORD_W-1:0];
        n.y   = ny[COORD_W-1:0];
        return n;
    endfunction

endpackage

// File: rtl/pipe_map.sv
// pipe_map: W x H grid of 2-bit cells, one synchronous write port and three
// combinational read ports. Anything off the grid reads as WALL.
module pipe_map
    import pipe_world_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [1:0]         wr_cell,
    input  logic [COORD_W-1:0] here_x,
    input  logic [COORD_W-1:0] here_y,
    input  logic               here_oob,
    output logic [1:0]         here_cell,
    input  logic [COORD_W-1:0] ahead_x,
    input  logic [COORD_W-1:0] ahead_y,
    input  logic               ahead_oob,
    output logic [1:0]         ahead_cell,
    input  logic [COORD_W-1:0] left_x,
    input  logic [COORD_W-1:0] left_y,
    input  logic               left_oob,
    output logic [1:0]         left_cell
);

    localparam int N = W * H;

    logic [1:0] grid_r [N];
    int         wr_idx_s;
    logic       wr_ok_s;

    // Looks up one cell; the scan keeps every index constant.
    function automatic logic [1:0] read_cell(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y,
                                             input logic oob);
        logic [1:0] c;
        int         idx;
        c   = CELL_WALL;
        idx = int'(y) * W + int'(x);
        if (oob || (int'(x) >= W) || (int'(y) >= H)) begin
            c = CELL_WALL;
        end else begin
            for (int i = 0; i < N; i++) begin
                c = (i == idx) ? grid_r[i] : c;
            end
        end
        return c;
    endfunction

    // Write address decode, rejecting coordinates off the grid.
    always_comb begin
        wr_idx_s = int'(wr_y) * W + int'(wr_x);
        wr_ok_s  = (int'(wr_x) < W) && (int'(wr_y) < H);
    end

    // Three independent read ports.
    always_comb begin
        here_cell  = read_cell(here_x, here_y, here_oob);
        ahead_cell = read_cell(ahead_x, ahead_y, ahead_oob);
        left_cell  = read_cell(left_x, left_y, left_oob);
    end

    // Grid storage: cleared to FREE on reset, single write per edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                grid_r[i] <= CELL_FREE;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (we && wr_ok_s && (i == wr_idx_s)) begin
                    grid_r[i] <= wr_cell;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_world.sv
// pipe_world: sensor-side world model for the cleaning robot. Sensors depend
// only on registered state, never on the incoming commands.
// Optional build macro PIPE_WORLD_STEP_LIMIT_EN adds a MAX_STEPS watchdog.
module pipe_world
    import pipe_world_pkg::*;
#(
    parameter int W             = 8,
    parameter int H             = 8,
    parameter int REMOVE_CYCLES = 2,
    parameter int CNT_W         = 16,
    parameter int MAX_STEPS     = 1024
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [$clog2(W)-1:0] cfg_x,
    input  logic [$clog2(H)-1:0] cfg_y,
    input  logic [1:0]           cfg_cell,
    input  logic                 start,
    input  logic [$clog2(W)-1:0] start_x,
    input  logic [$clog2(H)-1:0] start_y,
    input  logic [1:0]           start_dir,
    input  logic                 front,
    input  logic                 turn,
    input  logic                 remove,
    output logic                 head,
    output logic                 left,
    output logic                 under,
    output logic                 barrier,
    output logic [1:0]           state_o,
    output logic [1:0]           fault_code,
    output logic [CNT_W-1:0]     moves,
    output logic [CNT_W-1:0]     removed
);

    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int RW = $clog2(REMOVE_CYCLES) + 1;

    logic [XW-1:0]      pos_x_r;
    logic [YW-1:0]      pos_y_r;
    logic [1:0]         dir_r;
    state_t             state_r;
    fault_t             fault_r;
    logic [CNT_W-1:0]   moves_r;
    logic [CNT_W-1:0]   removed_r;
    logic [RW-1:0]      rm_cnt_r;

    nbr_t               ahead_nb_s;
    nbr_t               left_nb_s;
    logic [COORD_W-1:0] here_x_s;
    logic [COORD_W-1:0] here_y_s;
    logic [1:0]         here_cell_s;
    logic [1:0]         ahead_cell_s;
    logic [1:0]         left_cell_s;
    logic               map_we_s;
    logic [COORD_W-1:0] map_wx_s;
    logic [COORD_W-1:0] map_wy_s;
    logic [1:0]         map_wd_s;
    logic               multi_s;
    logic               any_cmd_s;
    logic               rm_done_s;
    logic               clear_trash_s;
    logic               step_limit_s;
    logic               sense_en_s;

    // Neighbour coordinates, command decode and the trash-clearing condition.
    always_comb begin
        ahead_nb_s    = neighbour(int'(pos_x_r), int'(pos_y_r), dir_r, W, H);
        left_nb_s     = neighbour(int'(pos_x_r), int'(pos_y_r), dir_r + 2'd3, W, H);
        multi_s       = (front & turn) | (front & remove) | (turn & remove);
        any_cmd_s     = front | turn | remove;
        rm_done_s     = (rm_cnt_r == RW'(REMOVE_CYCLES - 1));
        clear_trash_s = (state_r == ST_RUN) && !multi_s && !step_limit_s && remove &&
                        (ahead_cell_s == CELL_TRASH) && rm_done_s;
    end

    // In LOAD the "here" port checks the requested start cell instead of pos.
    always_comb begin
        if (state_r == ST_LOAD) begin
            here_x_s = COORD_W'(start_x);
            here_y_s = COORD_W'(start_y);
        end else begin
            here_x_s = COORD_W'(pos_x_r);
            here_y_s = COORD_W'(pos_y_r);
        end
    end

    // Map write mux: configuration in LOAD, trash clearing otherwise.
    always_comb begin
        if (state_r == ST_LOAD) begin
            map_we_s = cfg_we;
            map_wx_s = COORD_W'(cfg_x);
            map_wy_s = COORD_W'(cfg_y);
            map_wd_s = cfg_cell;
        end else begin
            map_we_s = clear_trash_s;
            map_wx_s = ahead_nb_s.x;
            map_wy_s = ahead_nb_s.y;
            map_wd_s = CELL_FREE;
        end
    end

    pipe_map #(.W(W), .H(H)) u_map (
        .clock      (clock),
        .reset      (reset),
        .we         (map_we_s),
        .wr_x       (map_wx_s),
        .wr_y       (map_wy_s),
        .wr_cell    (map_wd_s),
        .here_x     (here_x_s),
        .here_y     (here_y_s),
        .here_oob   (1'b0),
        .here_cell  (here_cell_s),
        .ahead_x    (ahead_nb_s.x),
        .ahead_y    (ahead_nb_s.y),
        .ahead_oob  (ahead_nb_s.oob),
        .ahead_cell (ahead_cell_s),
        .left_x     (left_nb_s.x),
        .left_y     (left_nb_s.y),
        .left_oob   (left_nb_s.oob),
        .left_cell  (left_cell_s)
    );

`ifdef PIPE_WORLD_STEP_LIMIT_EN
    localparam int SW = $clog2(MAX_STEPS + 1);
    logic [SW-1:0] step_cnt_r;

    assign step_limit_s = any_cmd_s && (step_cnt_r == SW'(MAX_STEPS - 1));

    // Watchdog: counts RUN cycles carrying a command, cleared on entry to RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_cnt_r <= '0;
        end else if ((state_r == ST_LOAD) && start && !cfg_we) begin
            step_cnt_r <= '0;
        end else if ((state_r == ST_RUN) && any_cmd_s && (step_cnt_r != '1)) begin
            step_cnt_r <= step_cnt_r + SW'(1);
        end
    end
`else
    logic unused_max_steps_s;
    assign step_limit_s       = 1'b0;
    assign unused_max_steps_s = (MAX_STEPS > 0);
`endif

    // World state machine: position, heading, counters and faults.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos_x_r   <= '0;
            pos_y_r   <= '0;
            dir_r     <= DIR_N;
            state_r   <= ST_LOAD;
            fault_r   <= FLT_NONE;
            moves_r   <= '0;
            removed_r <= '0;
            rm_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (start && !cfg_we) begin
                        pos_x_r   <= start_x;
                        pos_y_r   <= start_y;
                        dir_r     <= start_dir;
                        moves_r   <= '0;
                        removed_r <= '0;
                        rm_cnt_r  <= '0;
                        if ((here_cell_s == CELL_FREE) || (here_cell_s == CELL_EXIT)) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_FAULT;
                            fault_r <= FLT_BAD;
                        end
                    end
                end
                ST_RUN: begin
                    if (multi_s) begin
                        state_r <= ST_FAULT;
                        fault_r <= FLT_MULTI;
                    end else if (step_limit_s) begin
                        state_r <= ST_FAULT;
                        fault_r <= FLT_BAD;
                    end else if (front) begin
                        rm_cnt_r <= '0;
                        if ((ahead_cell_s == CELL_FREE) || (ahead_cell_s == CELL_EXIT)) begin
                            pos_x_r <= ahead_nb_s.x[XW-1:0];
                            pos_y_r <= ahead_nb_s.y[YW-1:0];
                            moves_r <= (moves_r == {CNT_W{1'b1}}) ? moves_r : moves_r + CNT_W'(1);
                            if (ahead_cell_s == CELL_EXIT) begin
                                state_r <= ST_DONE;
                            end
                        end else begin
                            state_r <= ST_FAULT;
                            fault_r <= FLT_COLLIDE;
                        end
                    end else if (turn) begin
                        dir_r    <= dir_r + 2'd1;
                        rm_cnt_r <= '0;
                    end else if (remove && (ahead_cell_s == CELL_TRASH)) begin
                        if (rm_done_s) begin
                            rm_cnt_r  <= '0;
                            removed_r <= (removed_r == {CNT_W{1'b1}}) ? removed_r
                                                                      : removed_r + CNT_W'(1);
                        end else begin
                            rm_cnt_r <= rm_cnt_r + RW'(1);
                        end
                    end else begin
                        rm_cnt_r <= '0;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        fault_r <= FLT_NONE;
                    end
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    // Sensors follow registered state; forced low while loading.
    always_comb begin
        sense_en_s = (state_r != ST_LOAD);
        head       = sense_en_s && (ahead_cell_s == CELL_WALL);
        left       = sense_en_s && (left_cell_s == CELL_WALL);
        under      = sense_en_s && (here_cell_s == CELL_EXIT);
        barrier    = sense_en_s && (ahead_cell_s == CELL_TRASH);
    end

    assign state_o    = state_r;
    assign fault_code = fault_r;
    assign moves      = moves_r;
    assign removed    = removed_r;

endmodule

// File: tb/tb_pipe_world.sv
// tb_pipe_world: directed closed-loop bench for pipe_world with a scoreboard queue.
module tb_pipe_world;

    localparam int MAX_STEPS_TB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_x = 3'd0;
    logic [2:0]  cfg_y = 3'd0;
    logic [1:0]  cfg_cell = 2'd0;
    logic        start = 1'b0;
    logic [2:0]  start_x = 3'd0;
    logic [2:0]  start_y = 3'd0;
    logic [1:0]  start_dir = 2'd0;
    logic        front = 1'b0;
    logic        turn = 1'b0;
    logic        remove = 1'b0;
    logic        head;
    logic        left;
    logic        under;
    logic        barrier;
    logic [1:0]  state_o;
    logic [1:0]  fault_code;
    logic [15:0] moves;
    logic [15:0] removed;

    always #5 clock = ~clock;

    pipe_world #(.W(8), .H(8), .REMOVE_CYCLES(2), .CNT_W(16), .MAX_STEPS(MAX_STEPS_TB)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_cell(cfg_cell),
        .start(start), .start_x(start_x), .start_y(start_y), .start_dir(start_dir),
        .front(front), .turn(turn), .remove(remove),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .state_o(state_o), .fault_code(fault_code), .moves(moves), .removed(removed)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  fc;
        logic        h;
        logic        l;
        logic        u;
        logic        b;
        logic [15:0] mv;
        logic [15:0] rm;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;

    function automatic obs_t mk(input logic [1:0] st, input logic [1:0] fc, input logic h,
                                input logic l, input logic u, input logic b,
                                input logic [15:0] mv, input logic [15:0] rm);
        obs_t o;
        o.st = st; o.fc = fc; o.h = h; o.l = l; o.u = u; o.b = b; o.mv = mv; o.rm = rm;
        return o;
    endfunction

    task automatic expect_push(input string tag, input obs_t v);
        sb_t item;
        item.tag = tag;
        item.v   = v;
        sb_q.push_back(item);
    endtask

    task automatic compare_next();
        sb_t  item;
        obs_t got;
        item = sb_q.pop_front();
        got  = mk(state_o, fault_code, head, left, under, barrier, moves, removed);
        checks++;
        assert (got === item.v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", item.tag, got, item.v);
        end
    endtask

    task automatic cmd(input logic f, input logic t, input logic r, input string tag, input obs_t ex);
        front = f; turn = t; remove = r;
        expect_push(tag, ex);
        @(posedge clock); #1;
        front = 1'b0; turn = 1'b0; remove = 1'b0;
        compare_next();
    endtask

    task automatic wr(input logic [2:0] x, input logic [2:0] y, input logic [1:0] c);
        cfg_we = 1'b1; cfg_x = x; cfg_y = y; cfg_cell = c;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d,
                      input string tag, input obs_t ex);
        start = 1'b1; start_x = x; start_y = y; start_dir = d;
        expect_push(tag, ex);
        @(posedge clock); #1;
        start = 1'b0;
        compare_next();
    endtask

    logic h_tab [4];
    logic l_tab [4];

    initial begin
        h_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
        l_tab = '{1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        expect_push("reset", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        compare_next();

        // walk east to a wall, turn around, walk back into the west edge
        wr(3'd3, 3'd0, 2'd1);
        go(3'd0, 3'd0, 2'd1, "t1_start", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t1_f1", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t1_f2", mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0));
        cmd(1'b0, 1'b1, 1'b0, "t1_turn_s", mk(2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0));
        cmd(1'b0, 1'b1, 1'b0, "t1_turn_w", mk(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t1_f3", mk(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t1_f4", mk(2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t1_collide", mk(2'd3, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0));
        cmd(1'b0, 1'b1, 1'b0, "t1_frozen", mk(2'd3, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0));
        go(3'd0, 3'd0, 2'd0, "t1_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd0));

        // trash removal, interrupted once, then multi-command fault
        wr(3'd1, 3'd0, 2'd2);
        go(3'd0, 3'd0, 2'd1, "t2_start", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0));
        cmd(1'b0, 1'b0, 1'b1, "t2_rm1", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0));
        cmd(1'b0, 1'b0, 1'b0, "t2_idle", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0));
        cmd(1'b0, 1'b0, 1'b1, "t2_rm1b", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0));
        cmd(1'b0, 1'b0, 1'b1, "t2_rm2", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1));
        cmd(1'b1, 1'b0, 1'b0, "t2_f1", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1));
        cmd(1'b1, 1'b0, 1'b0, "t2_f2", mk(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1));
        cmd(1'b1, 1'b1, 1'b0, "t2_multi", mk(2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1));
        go(3'd0, 3'd0, 2'd0, "t2_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1));

        // reach the exit, then commands are ignored
        wr(3'd0, 3'd1, 2'd3);
        go(3'd0, 3'd0, 2'd0, "t3_start", mk(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t3_exit", mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t3_done_f", mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0));
        cmd(1'b0, 1'b1, 1'b0, "t3_done_t", mk(2'd2, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 16'd0));
        go(3'd0, 3'd0, 2'd0, "t3_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));

        // start on a wall
        go(3'd3, 3'd0, 2'd0, "t4_bad", mk(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        go(3'd0, 3'd0, 2'd0, "t4_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));

        // start together with a write: the write lands, the start is dropped
        cfg_we = 1'b1; cfg_x = 3'd2; cfg_y = 3'd2; cfg_cell = 2'd2;
        go(3'd2, 3'd2, 2'd0, "t5_we_start", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        cfg_we = 1'b0;
        go(3'd2, 3'd2, 2'd0, "t5_trash_start", mk(2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        go(3'd0, 3'd0, 2'd0, "t5_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));

        // repeated turns: heading cycles, watchdog trips on the last one when enabled
        go(3'd0, 3'd0, 2'd0, "t6_start", mk(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0));
        for (int k = 1; k < MAX_STEPS_TB; k++) begin
            cmd(1'b0, 1'b1, 1'b0, $sformatf("t6_turn%0d", k),
                mk(2'd1, 2'd0, h_tab[k % 4], l_tab[k % 4], 1'b0, 1'b0, 16'd0, 16'd0));
        end
`ifdef PIPE_WORLD_STEP_LIMIT_EN
        turn = 1'b1;
        @(posedge clock); #1;
        turn = 1'b0;
        checks++;
        assert (state_o === 2'd3) else begin
            failures++;
            $error("FAIL t6_limit_state observed=%0d expected=3", state_o);
        end
        checks++;
        assert (fault_code === 2'd3) else begin
            failures++;
            $error("FAIL t6_limit_code observed=%0d expected=3", fault_code);
        end
        go(3'd0, 3'd0, 2'd0, "t6_to_load", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        go(3'd0, 3'd0, 2'd0, "t6_restart", mk(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0));
`else
        cmd(1'b0, 1'b1, 1'b0, "t6_no_limit",
            mk(2'd1, 2'd0, h_tab[MAX_STEPS_TB % 4], l_tab[MAX_STEPS_TB % 4], 1'b0, 1'b0, 16'd0, 16'd0));
`endif

        // reset mid-run clears everything, including the map
        reset = 1'b0;
        #2;
        expect_push("t7_reset", mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        compare_next();
        reset = 1'b1;
        @(posedge clock); #1;
        go(3'd3, 3'd0, 2'd0, "t7_map_cleared", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        cmd(1'b1, 1'b0, 1'b0, "t7_f1", mk(2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
